toggle_period_meter: RTL
========================

// Module: toggle_period_meter
// PURPOSE
//  Input-side counterpart of the team's LED blink counter: measures the half-period
//  of a slow toggling input (blink output, external square wave) in clk cycles.
//  Delivers each result on a valid/ready interface and flags timeouts (stuck input)
//  and overruns (unread result overwritten). Used for loopback checks of blink timing.
// PARAMETERS
//  CNT_WIDTH  32          width of internal counter and period_out
//  TIMEOUT    100_000_000 cycles without an edge before timeout (must be < 2**CNT_WIDTH)
//  FILT_LEN   4           stable cycles required by glitch filter (only with GLITCH_FILTER_EN)
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  rst           in   1          synchronous reset, active-low
//  sig_in        in   1          asynchronous toggling input
//  meas_en       in   1          1 = measure; 0 = return to IDLE, counter cleared
//  period_out    out  CNT_WIDTH  cycles between two consecutive detected edges
//  period_valid  out  1          result held until accepted
//  period_ready  in   1          consumer accepts when valid && ready on a posedge
//  timeout       out  1          1-cycle pulse: no edge within TIMEOUT cycles
//  overrun       out  1          sticky: result overwritten while unaccepted
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, sync flops=0, counter=0, period_out=0,
//    period_valid=0, timeout=0, overrun=0. Reset mid-measurement discards everything.
//  - sig_in -> 2-flop synchronizer -> one delay flop; edge = sync ^ delayed (both
//    edges count, so result = half-period). Pin edge to edge pulse: 3 cycles.
//  - FSM:
//    IDLE : counter=0. meas_en=1 -> ARM.
//    ARM  : wait first edge; counter held 0. edge -> MEAS with counter=1.
//    MEAS : counter+1 each cycle (saturates at all-ones, never wraps).
//           edge -> period_out<=counter, period_valid<=1, counter<=1, stay MEAS.
//           counter==TIMEOUT w/o edge -> timeout pulse 1 cycle, counter<=0, -> ARM.
//    any state: meas_en=0 -> IDLE next cycle; pending result and overrun kept.
//  - Result value: edge pulses N cycles apart give period_out=N. Visible the cycle
//    after the edge pulse (result latency 1 from edge pulse, 4 from pin).
//  - Handshake: period_valid clears on cycle after valid&&ready. New result while
//    valid&&!ready: period_out overwritten, valid stays 1, overrun<=1.
//    New result in same cycle as accept: new value loaded, valid stays 1, no overrun.
//  - overrun cleared only by reset. timeout and result never in the same cycle
//    (edge wins: edge on the TIMEOUT cycle is a normal result).
// CONFIGURATION
//  GLITCH_FILTER_EN defined: after synchronizer, filtered level changes only when sync
//    output held a new value FILT_LEN consecutive cycles; edge detect uses filtered level.
//    Adds FILT_LEN cycles latency; pulses shorter than FILT_LEN cycles ignored.
//  GLITCH_FILTER_EN undefined: no filter, FILT_LEN unused, latency as above.
// TESTING
//  1 rst=0 2 cycles, release, meas_en=1, sig_in toggles every 10 clk -> first result
//    period_out=10, period_valid=1; every following result 10.
//  2 ready held 1 -> each valid high exactly 1 cycle, overrun stays 0.
//  3 ready held 0 over 3 results -> period_valid stays 1, period_out=latest, overrun=1.
//  4 TIMEOUT=50, sig_in static after 1 edge -> timeout pulse 50 cycles after counter
//    start, no valid; next 2 edges 20 apart -> period_out=20.
//  5 meas_en=0 mid-MEAS then 1 -> first edge only re-arms; result after second edge.
//  6 rst=0 mid-MEAS with valid=1 -> all outputs 0 next cycle; GLITCH_FILTER_EN build:
//    2-cycle glitch on sig_in (FILT_LEN=4) -> no edge, no result.

Source files
------------

// File: rtl/toggle_period_meter.sv
// ---------------------------------------------------------------------------
// toggle_period_meter
//
// Measures the half-period of a slow toggling input (for example the blink
// output of the LED blink counter looped back, or an external square wave)
// in clk cycles. Both edges of the input are counted, so each result is the
// number of cycles between two consecutive level changes.
//
// Results are delivered on a valid/ready interface. A result that is
// replaced before the consumer took it raises a sticky overrun flag. When the
// input stops toggling for TIMEOUT cycles a one-cycle timeout pulse is
// produced and the meter re-arms, waiting for the next edge.
//
// Optional feature (compile-time macro):
//   GLITCH_FILTER_EN  when defined, the synchronised input only changes its
//                     filtered level after holding a new value for FILT_LEN
//                     consecutive cycles. Shorter pulses are ignored and edge
//                     detection gains FILT_LEN cycles of latency. When the
//                     macro is undefined the filter is absent.
//
// Parameters:
//   CNT_WIDTH  width of the cycle counter and of period_o
//   TIMEOUT    cycles without an edge before a timeout (< 2**CNT_WIDTH)
//   FILT_LEN   stable cycles required by the glitch filter
//
// Ports:
//   clk_i           system clock, all logic on the rising edge
//   rst_ni          synchronous reset, active low
//   sig_i           asynchronous toggling input being measured
//   meas_en_i       1 = measure, 0 = return to idle with the counter cleared
//   period_o        cycles between the two most recent detected edges
//   period_valid_o  result available, held until accepted
//   period_ready_i  consumer accepts when valid and ready on a rising edge
//   timeout_o       one-cycle pulse: no edge within TIMEOUT cycles
//   overrun_o       sticky: an unaccepted result was overwritten
// ---------------------------------------------------------------------------
module toggle_period_meter #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 100_000_000,
  parameter int unsigned FILT_LEN  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sig_i,
  input  logic                 meas_en_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  input  logic                 period_ready_i,
  output logic                 timeout_o,
  output logic                 overrun_o
);

  // Reject parameter sets that cannot work: the filter needs at least one
  // stable cycle, and the counter has to be able to reach TIMEOUT.
  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("toggle_period_meter: FILT_LEN must be at least 1");
  end
  if ((TIMEOUT < 1) ||
      ((CNT_WIDTH < 32) && ((64'(TIMEOUT) >> CNT_WIDTH) != 64'd0))) begin : g_bad_timeout
    $error("toggle_period_meter: TIMEOUT must be in 1 .. 2**CNT_WIDTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 level;
  logic                 level_dly_q;
  logic                 edge_det;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_sat_d;
  logic                 timeout_hit;

  logic [CNT_WIDTH-1:0] period_q;
  logic                 period_valid_q;
  logic                 timeout_q;
  logic                 overrun_q;

  // Two-flop synchroniser for the asynchronous input. The flops are cleared
  // on reset so that a low input produces no spurious edge after release.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic           filt_q;
  logic [FCW-1:0] filt_cnt_q;

  // Glitch filter: the run counter tracks how many consecutive cycles the
  // synchronised input has disagreed with the filtered level. Any cycle of
  // agreement restarts the run, so only a level held for FILT_LEN cycles
  // gets through.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
      filt_q     <= sync2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // One delay flop behind the (filtered) level; any difference is an edge,
  // rising or falling.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_dly_q <= 1'b0;
    end else begin
      level_dly_q <= level;
    end
  end

  assign edge_det = level ^ level_dly_q;

  // The counter saturates at all-ones instead of wrapping, so a huge period
  // can never masquerade as a short one.
  assign cnt_sat_d   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_q == TIMEOUT_VAL);

  // Measurement FSM together with the result handshake.
  // The counter starts at 1 on the arming edge, so when the next edge arrives
  // N cycles later it holds exactly N. An edge on the cycle the counter hits
  // TIMEOUT is still a normal result; the timeout branch is only taken
  // without an edge. Dropping meas_en returns to idle but keeps any pending
  // result and the overrun flag so the consumer can still collect them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;

      if (period_valid_q && period_ready_i) begin
        period_valid_q <= 1'b0;
      end

      if (!meas_en_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end

          ARM: begin
            if (edge_det) begin
              cnt_q   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              state_q <= MEAS;
            end else begin
              cnt_q <= '0;
            end
          end

          MEAS: begin
            if (edge_det) begin
              // A new result overrides the accept-clear above; it only
              // counts as an overrun if the old one was not taken now.
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (period_valid_q && !period_ready_i) begin
                overrun_q <= 1'b1;
              end
              cnt_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (timeout_hit) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q <= cnt_sat_d;
            end
          end

          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign timeout_o      = timeout_q;
  assign overrun_o      = overrun_q;

endmodule
